interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 27 ++
 rtl/interrupt_controller.sv | 164 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Interrupt-side handshake bundle: peripheral raise/ack lines and the
// processor request/vector/taken handshake.
interface interrupt_controller_if;
   logic [3:0] IRQ_RAISE;
   logic [3:0] IRQ_ACK;
   logic       CPU_INT_REQ;
   logic [1:0] CPU_INT_VECTOR;
   logic       CPU_INT_TAKEN;

   // Controller side
   modport master (
      input  IRQ_RAISE,
      input  CPU_INT_TAKEN,
      output IRQ_ACK,
      output CPU_INT_REQ,
      output CPU_INT_VECTOR
   );

   // Peripheral / processor side
   modport slave (
      output IRQ_RAISE,
      output CPU_INT_TAKEN,
      input  IRQ_ACK,
      input  CPU_INT_REQ,
      input  CPU_INT_VECTOR
   );
endinterface

// File: rtl/interrupt_controller.sv
// Four-source fixed-priority interrupt controller. Edge-detects raise lines
// into sticky pending bits, gates them with a bus-writable mask, and serves
// one source at a time through an IDLE -> REQUEST -> ACK handshake.
// Register block (8-bit bus): +0 pending (RO), +1 mask (RW), +2 W1C clear
// of pending (reads 0), +3 {state, vector} status.
module interrupt_controller #(
   parameter logic [7:0] BaseAddr    = 8'hE0,
   parameter logic [3:0] InitialMask = 4'b1111
) (
   input  logic                    CLK,
   input  logic                    RESET,
   inout  wire  [7:0]              BUS_DATA,
   input  logic [7:0]              BUS_ADDR,
   input  logic                    BUS_WE,
   interrupt_controller_if.master  irq
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      ACK     = 2'd2
   } state_t;

   state_t     state_reg;
   logic [3:0] prev_raise_reg;
   logic [3:0] pending_reg;
   logic [3:0] pending_next;
   logic [3:0] mask_reg;
   logic [1:0] vector_reg;
   logic [3:0] irq_ack_reg;
   logic       cpu_int_req_reg;
   logic       rd_oe_reg;
   logic [7:0] rd_data_reg;

   logic [7:0] offset;
   logic       in_window;
   logic       wr_mask;
   logic       wr_clear;
   logic       rd_hit;
   logic [3:0] edge_set;
   logic [3:0] bus_clear;
   logic [3:0] taken_clear;
   logic [3:0] eligible;
   logic       eligible_any;
   logic [1:0] winner;
   logic [7:0] rd_value;

   // Address decode relative to the block base; wraps in 8 bits
   assign offset    = BUS_ADDR - BaseAddr;
   assign in_window = (offset[7:2] == 6'd0);
   assign wr_mask   = in_window && BUS_WE && (offset[1:0] == 2'd1);
   assign wr_clear  = in_window && BUS_WE && (offset[1:0] == 2'd2);
   assign rd_hit    = in_window && !BUS_WE;

   // The processor's acceptance clears the bit of the source being served
   assign taken_clear = (state_reg == REQUEST && irq.CPU_INT_TAKEN)
                        ? (4'b0001 << vector_reg) : 4'b0000;

   // Per-source pending logic: a fresh rising edge always beats any clear
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_src
         assign edge_set[gi]     = irq.IRQ_RAISE[gi] & ~prev_raise_reg[gi];
         assign bus_clear[gi]    = wr_clear & BUS_DATA[gi];
         assign pending_next[gi] = edge_set[gi] |
                                   (pending_reg[gi] & ~(bus_clear[gi] | taken_clear[gi]));
         assign eligible[gi]     = pending_reg[gi] & mask_reg[gi];
      end
   endgenerate

   assign eligible_any = |eligible;

   // Fixed-priority encoder: lowest eligible index wins
   always_comb begin
      winner = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = 2'(i);
         end
      end
   end

   // Read-back mux for the register block
   always_comb begin
      rd_value = 8'h00;
      case (offset[1:0])
         2'd0:    rd_value = {4'b0000, pending_reg};
         2'd1:    rd_value = {4'b0000, mask_reg};
         2'd2:    rd_value = 8'h00;
         default: rd_value = {4'b0000, state_reg, vector_reg};
      endcase
   end

   // Edge history, pending bits and mask register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_raise_reg <= 4'b0000;
         pending_reg    <= 4'b0000;
         mask_reg       <= InitialMask;
      end else begin
         prev_raise_reg <= irq.IRQ_RAISE;
         pending_reg    <= pending_next;
         if (wr_mask) begin
            mask_reg <= BUS_DATA[3:0];
         end
      end
   end

   // Service FSM with registered request/ack outputs; a request, once
   // issued, is held for the latched vector regardless of later changes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg       <= IDLE;
         vector_reg      <= 2'd0;
         cpu_int_req_reg <= 1'b0;
         irq_ack_reg     <= 4'b0000;
      end else begin
         case (state_reg)
            IDLE: begin
               irq_ack_reg <= 4'b0000;
               if (eligible_any) begin
                  vector_reg      <= winner;
                  cpu_int_req_reg <= 1'b1;
                  state_reg       <= REQUEST;
               end
            end
            REQUEST: begin
               if (irq.CPU_INT_TAKEN) begin
                  cpu_int_req_reg <= 1'b0;
                  irq_ack_reg     <= 4'b0001 << vector_reg;
                  state_reg       <= ACK;
               end
            end
            ACK: begin
               irq_ack_reg <= 4'b0000;
               state_reg   <= IDLE;
            end
            default: begin
               cpu_int_req_reg <= 1'b0;
               irq_ack_reg     <= 4'b0000;
               state_reg       <= IDLE;
            end
         endcase
      end
   end

   // Register reads: capture data and enable together, drive next cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_oe_reg   <= 1'b0;
         rd_data_reg <= 8'h00;
      end else begin
         rd_oe_reg <= rd_hit;
         if (rd_hit) begin
            rd_data_reg <= rd_value;
         end
      end
   end

   assign BUS_DATA           = rd_oe_reg ? rd_data_reg : 8'bzzzz_zzzz;
   assign irq.IRQ_ACK        = irq_ack_reg;
   assign irq.CPU_INT_REQ    = cpu_int_req_reg;
   assign irq.CPU_INT_VECTOR = vector_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a directed vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// behavioural model. The bus carries pull-ups so an undriven bus reads 8'hFF.
module tb_interrupt_controller;
   localparam logic [7:0] BASE = 8'hE0;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = 8'h00;
   logic [7:0] tb_data = 8'h00;
   wire  [7:0] bus;

   int n_checks = 0;
   int n_errors = 0;

   interrupt_controller_if ifc ();

   assign bus = tb_we ? tb_data : 8'bzzzz_zzzz;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pull
         pullup (bus[gi]);
      end
   endgenerate

   interrupt_controller #(.BaseAddr(BASE), .InitialMask(4'b1111)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .BUS_DATA (bus),
      .BUS_ADDR (tb_addr),
      .BUS_WE   (tb_we),
      .irq      (ifc)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit       rst;
      bit [3:0] raise;
      bit       we;
      bit [7:0] addr;
      bit [7:0] data;
      bit       taken;
      bit       exp_req;
      bit [1:0] exp_vec;
      bit [3:0] exp_ack;
      bit [7:0] exp_bus;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit [3:0] raise, bit we, bit [7:0] addr,
                               bit [7:0] data, bit taken, bit req, bit [1:0] vec,
                               bit [3:0] ack, bit [7:0] bv);
      vec_t v;
      v.rst = rst; v.raise = raise; v.we = we; v.addr = addr; v.data = data;
      v.taken = taken; v.exp_req = req; v.exp_vec = vec; v.exp_ack = ack;
      v.exp_bus = bv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, sample just after the edge
   task automatic step(input bit rst, input bit [3:0] raise, input bit we,
                       input bit [7:0] addr, input bit [7:0] data, input bit taken);
      RESET             = rst;
      ifc.IRQ_RAISE     = raise;
      tb_we             = we;
      tb_addr           = addr;
      tb_data           = data;
      ifc.CPU_INT_TAKEN = taken;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_outs(input string tag, input bit req, input bit [1:0] vec,
                           input bit [3:0] ack, input bit [7:0] bv);
      chk({tag, "_req"}, {7'b0, ifc.CPU_INT_REQ}, {7'b0, req});
      chk({tag, "_ack"}, {4'b0, ifc.IRQ_ACK}, {4'b0, ack});
      chk({tag, "_bus"}, bus, bv);
      if (req) chk({tag, "_vec"}, {6'b0, ifc.CPU_INT_VECTOR}, {6'b0, vec});
   endtask

   // Hold raise lines and wait (bounded) for a request to appear
   task automatic wait_req(input string tag, input bit [3:0] raise);
      int n;
      n = 0;
      while (!ifc.CPU_INT_REQ && n < 6) begin
         step(1'b0, raise, 1'b0, 8'h00, 8'h00, 1'b0);
         n++;
      end
      chk({tag, "_req_seen"}, {7'b0, ifc.CPU_INT_REQ}, 8'h01);
   endtask

   // ---------------- behavioural reference model ----------------
   bit [3:0] m_pend, m_mask, m_prev;
   int       m_serv;     // source currently being served, -1 when none
   bit       m_ackph;    // this cycle is the acknowledge cycle
   bit [1:0] m_vec;      // last granted source
   bit       m_rdv;
   bit [7:0] m_rdd;

   task automatic model_step(input bit rst, input bit [3:0] raise, input bit we,
                             input bit [7:0] addr, input bit [7:0] data, input bit taken);
      int off, st;
      bit [3:0] p0, setb, clrb;
      if (rst) begin
         m_pend = 0; m_mask = 4'hF; m_prev = 0; m_serv = -1; m_ackph = 0;
         m_vec = 0; m_rdv = 0; m_rdd = 0;
         return;
      end
      p0  = m_pend;
      off = int'(addr) - int'(BASE);
      st  = m_ackph ? 2 : ((m_serv >= 0) ? 1 : 0);
      m_rdv = !we && off >= 0 && off < 4;
      if (m_rdv) begin
         case (off)
            0: m_rdd = {4'b0, p0};
            1: m_rdd = {4'b0, m_mask};
            2: m_rdd = 8'h00;
            default: m_rdd = 8'(st * 4 + int'(m_vec));
         endcase
      end
      setb = raise & ~m_prev;
      clrb = (we && off == 2) ? data[3:0] : 4'b0000;
      if (m_ackph) begin
         m_ackph = 0;
         m_serv  = -1;
      end else if (m_serv >= 0) begin
         if (taken) begin
            clrb[m_serv] = 1'b1;
            m_ackph = 1;
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (p0[i] && m_mask[i]) m_serv = i;
         end
         if (m_serv >= 0) m_vec = 2'(m_serv);
      end
      m_pend = (p0 & ~clrb) | setb;
      if (we && off == 1) m_mask = data[3:0];
      m_prev = raise;
   endtask

   initial begin
      bit [3:0] raise, e_ack;
      bit       last_rd, rst, we, taken, e_req;
      bit [7:0] addr, data, e_bus;
      int       op;

      ifc.IRQ_RAISE = 4'b0;
      ifc.CPU_INT_TAKEN = 1'b0;
      #2;

      // rst, raise, we, addr, data, taken | req, vec, ack, bus
      tbl.push_back(mk(1, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h2, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h2, 0, 8'h00, 8'h00, 0, 1, 1, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h2, 0, 8'hE3, 8'h00, 0, 1, 1, 4'h0, 8'h05));
      tbl.push_back(mk(0, 4'h2, 0, 8'h00, 8'h00, 0, 1, 1, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h2, 0, 8'h00, 8'h00, 1, 0, 0, 4'h2, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h00));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 1, 8'hE1, 8'h0E, 0, 0, 0, 4'h0, 8'h0E));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h1, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h01));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h1, 1, 8'hE1, 8'h0F, 0, 0, 0, 4'h0, 8'h0F));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 1, 0, 0, 4'h1, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h00));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 1, 8'hE1, 8'h00, 0, 0, 0, 4'h0, 8'h00));
      tbl.push_back(mk(0, 4'h5, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h5, 1, 8'hE2, 8'h04, 0, 0, 0, 4'h0, 8'h04));
      tbl.push_back(mk(0, 4'h5, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h01));
      tbl.push_back(mk(0, 4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h5, 1, 8'hE2, 8'h04, 0, 0, 0, 4'h0, 8'h04));
      tbl.push_back(mk(0, 4'h5, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h05));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 1, 8'hE2, 8'h0F, 0, 0, 0, 4'h0, 8'h0F));
      tbl.push_back(mk(0, 4'h0, 1, 8'hE1, 8'h0F, 0, 0, 0, 4'h0, 8'h0F));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE1, 8'h00, 0, 0, 0, 4'h0, 8'h0F));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 1, 8'hE4, 8'h00, 0, 0, 0, 4'h0, 8'h00));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE5, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE1, 8'h00, 0, 0, 0, 4'h0, 8'h0F));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));
      tbl.push_back(mk(0, 4'h0, 0, 8'hE0, 8'h00, 0, 0, 0, 4'h0, 8'h00));
      tbl.push_back(mk(0, 4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF));

      for (int r = 0; r < tbl.size(); r++) begin
         step(tbl[r].rst, tbl[r].raise, tbl[r].we, tbl[r].addr, tbl[r].data, tbl[r].taken);
         $display("row %0d: raise=%h we=%0d addr=%h taken=%0d -> req=%0d vec=%0d ack=%h bus=%h",
                  r, tbl[r].raise, tbl[r].we, tbl[r].addr, tbl[r].taken,
                  ifc.CPU_INT_REQ, ifc.CPU_INT_VECTOR, ifc.IRQ_ACK, bus);
         chk_outs($sformatf("row%0d", r), tbl[r].exp_req, tbl[r].exp_vec,
                  tbl[r].exp_ack, tbl[r].exp_bus);
      end

      // Simultaneous sources 3 and 0: 0 served first, then 3
      step(1'b0, 4'h9, 1'b0, 8'h00, 8'h00, 1'b0);
      wait_req("pri_first", 4'h9);
      chk_outs("pri_first", 1'b1, 2'd0, 4'h0, 8'hFF);
      step(1'b0, 4'h9, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("pri_ack0", 1'b0, 2'd0, 4'h1, 8'hFF);
      step(1'b0, 4'h8, 1'b0, 8'h00, 8'h00, 1'b0);
      chk_outs("pri_idle", 1'b0, 2'd0, 4'h0, 8'hFF);
      wait_req("pri_second", 4'h8);
      chk_outs("pri_second", 1'b1, 2'd3, 4'h0, 8'hFF);
      step(1'b0, 4'h8, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("pri_ack3", 1'b0, 2'd0, 4'h8, 8'hFF);
      step(1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      $display("seq priority: ack order checked");

      // TAKEN clear collides with a fresh edge on the same source
      step(1'b0, 4'h2, 1'b0, 8'h00, 8'h00, 1'b0);
      wait_req("tk_first", 4'h2);
      chk_outs("tk_first", 1'b1, 2'd1, 4'h0, 8'hFF);
      step(1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 4'h2, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("tk_ack", 1'b0, 2'd0, 4'h2, 8'hFF);
      step(1'b0, 4'h2, 1'b0, 8'h00, 8'h00, 1'b0);
      chk_outs("tk_idle", 1'b0, 2'd0, 4'h0, 8'hFF);
      step(1'b0, 4'h2, 1'b0, 8'h00, 8'h00, 1'b0);
      chk_outs("tk_again", 1'b1, 2'd1, 4'h0, 8'hFF);
      step(1'b0, 4'h2, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("tk_ack2", 1'b0, 2'd0, 4'h2, 8'hFF);
      step(1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      $display("seq taken-vs-edge done");

      // Reset during REQUEST aborts; held raise is re-detected afterwards
      step(1'b0, 4'h0, 1'b1, 8'hE1, 8'h06, 1'b0);
      step(1'b0, 4'h4, 1'b0, 8'h00, 8'h00, 1'b0);
      wait_req("rst_pre", 4'h4);
      chk_outs("rst_pre", 1'b1, 2'd2, 4'h0, 8'hFF);
      step(1'b1, 4'h4, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("rst_in", 1'b0, 2'd0, 4'h0, 8'hFF);
      step(1'b0, 4'h4, 1'b0, 8'h00, 8'h00, 1'b0);
      chk_outs("rst_post1", 1'b0, 2'd0, 4'h0, 8'hFF);
      step(1'b0, 4'h4, 1'b0, 8'hE1, 8'h00, 1'b0);
      chk_outs("rst_post2", 1'b1, 2'd2, 4'h0, 8'h0F);
      step(1'b0, 4'h4, 1'b0, 8'h00, 8'h00, 1'b1);
      chk_outs("rst_ack", 1'b0, 2'd0, 4'h4, 8'hFF);
      step(1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      $display("seq reset-abort done");

      // Randomized run against the behavioural model
      model_step(1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0);
      raise = 0; e_ack = 0; last_rd = 0;
      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 4; i++) begin
            if (e_ack[i]) raise[i] = 1'b0;
            else if (!raise[i] && $urandom_range(0, 7) == 0) raise[i] = 1'b1;
            else if (raise[i] && $urandom_range(0, 39) == 0) raise[i] = 1'b0;
         end
         op = $urandom_range(0, 9);
         we = 0; addr = 8'h00; data = 8'($urandom);
         if (op < 2 && !last_rd && !rst) begin
            we = 1; addr = BASE + 8'($urandom_range(0, 4));
         end else if (op >= 2 && op < 5) begin
            addr = BASE + 8'($urandom_range(0, 5));
         end
         taken = ($urandom_range(0, 2) == 0);
         last_rd = !we && !rst && (addr != 8'h00);

         model_step(rst, raise, we, addr, data, taken);
         e_req = (m_serv >= 0) && !m_ackph;
         e_ack = m_ackph ? (4'b0001 << m_serv) : 4'b0000;
         e_bus = we ? data : (m_rdv ? m_rdd : 8'hFF);
         step(rst, raise, we, addr, data, taken);
         $display("rnd %0d: rst=%0d raise=%h we=%0d addr=%h taken=%0d -> req=%0d vec=%0d ack=%h bus=%h",
                  n, rst, raise, we, addr, taken, ifc.CPU_INT_REQ, ifc.CPU_INT_VECTOR,
                  ifc.IRQ_ACK, bus);
         chk_outs($sformatf("rnd%0d", n), e_req, m_vec, e_ack, e_bus);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
